multdiv_stall_controller: RTL and testbench

- Execute-stage sequencer for the shared multi-cycle multiplier/divider in the 5-stage pipeline (fetch/decode/execute/memory/writeback).
- Accepts a mul/div request from execute and pulses the unit's start control.
- Holds the pipeline stall until the result is ready, then presents a single writeback.
- On a unit exception or timeout, redirects that writeback to rstatus ($30).

---
 rtl/multdiv_stall_controller_pkg.sv | 19 +
 rtl/multdiv_timeout_counter.sv | 29 ++
 rtl/multdiv_stall_controller.sv | 145 ++++++++++++++
 tb/tb_multdiv_stall_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_stall_controller_pkg.sv
// Shared constants for the mul/div sequencer and the writeback stage.
package multdiv_stall_controller_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned DATA_W  = 32;

  // Sequencer FSM encoding
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_START = 2'd1;
  localparam logic [STATE_W-1:0] ST_BUSY  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

  // Exception writeback target and codes
  localparam int unsigned MDS_RSTATUS_REG  = 30;
  localparam int unsigned MDS_MUL_EXC_CODE = 4;
  localparam int unsigned MDS_DIV_EXC_CODE = 5;

endpackage

// File: rtl/multdiv_timeout_counter.sv
// BUSY-cycle counter with synchronous clear and a terminal-count flag.
module multdiv_timeout_counter #(
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned TERMINAL = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal_c
);

  logic [CNT_W-1:0] count_q;

  // Count enabled cycles; clear has priority over enable
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Flags the last permitted cycle before abort
  assign terminal_c = (count_q == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/multdiv_stall_controller.sv
// Execute-stage sequencer for the shared multi-cycle multiplier/divider.
module multdiv_stall_controller
  import multdiv_stall_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6,
  parameter int unsigned RSTATUS_REG    = MDS_RSTATUS_REG,
  parameter int unsigned MUL_EXC_CODE   = MDS_MUL_EXC_CODE,
  parameter int unsigned DIV_EXC_CODE   = MDS_DIV_EXC_CODE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_start_mul,
  input  logic              i_start_div,
  input  logic [REG_W-1:0]  i_rd,
  input  logic              i_flush,
  input  logic              data_resultRDY,
  input  logic              data_exception,
  input  logic [DATA_W-1:0] data_result,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  output logic              o_stall,
  output logic              o_wb_valid,
  output logic [REG_W-1:0]  o_wb_rd,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_busy
);

  localparam logic [REG_W-1:0]  RSTATUS  = REG_W'(RSTATUS_REG);
  localparam logic [DATA_W-1:0] MUL_CODE = DATA_W'(MUL_EXC_CODE);
  localparam logic [DATA_W-1:0] DIV_CODE = DATA_W'(DIV_EXC_CODE);

  logic [STATE_W-1:0] state_q, state_d;
  logic               op_mul_q, op_mul_d;
  logic [REG_W-1:0]   rd_q, rd_d;
  logic               ctrl_mult_d, ctrl_div_d;
  logic               wb_valid_d;
  logic [REG_W-1:0]   wb_rd_d;
  logic [DATA_W-1:0]  wb_data_d;
  logic               busy_d;
  logic               request_c;
  logic               cnt_clear_c, cnt_en_c, cnt_tc_c;

  multdiv_timeout_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear_c),
    .enable     (cnt_en_c),
    .terminal_c (cnt_tc_c)
  );

  assign request_c = (i_start_mul | i_start_div) & ~i_flush;

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_mul_q   <= 1'b0;
      rd_q       <= '0;
      ctrl_MULT  <= 1'b0;
      ctrl_DIV   <= 1'b0;
      o_wb_valid <= 1'b0;
      o_wb_rd    <= '0;
      o_wb_data  <= '0;
      o_busy     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_mul_q   <= op_mul_d;
      rd_q       <= rd_d;
      ctrl_MULT  <= ctrl_mult_d;
      ctrl_DIV   <= ctrl_div_d;
      o_wb_valid <= wb_valid_d;
      o_wb_rd    <= wb_rd_d;
      o_wb_data  <= wb_data_d;
      o_busy     <= busy_d;
    end
  end

  // Next-state, next-output and combinational stall
  always_comb begin
    state_d     = state_q;
    op_mul_d    = op_mul_q;
    rd_d        = rd_q;
    ctrl_mult_d = 1'b0;
    ctrl_div_d  = 1'b0;
    wb_valid_d  = 1'b0;
    wb_rd_d     = o_wb_rd;
    wb_data_d   = o_wb_data;
    o_stall     = 1'b0;
    cnt_clear_c = 1'b0;
    cnt_en_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        o_stall = request_c;
        if (request_c) begin
          // Multiply wins when both starts are raised
          state_d     = ST_START;
          op_mul_d    = i_start_mul;
          rd_d        = i_rd;
          ctrl_mult_d = i_start_mul;
          ctrl_div_d  = ~i_start_mul;
        end
      end
      ST_START: begin
        o_stall     = 1'b1;
        cnt_clear_c = 1'b1;
        state_d     = i_flush ? ST_IDLE : ST_BUSY;
      end
      ST_BUSY: begin
        o_stall  = 1'b1;
        cnt_en_c = 1'b1;
        if (i_flush) begin
          state_d = ST_IDLE;
        end else if (data_resultRDY) begin
          state_d = ST_DONE;
          if (data_exception) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = RSTATUS;
            wb_data_d  = op_mul_q ? MUL_CODE : DIV_CODE;
          end else begin
            // Writes to r0 are dropped
            wb_valid_d = (rd_q != '0);
            wb_rd_d    = rd_q;
            wb_data_d  = data_result;
          end
        end else if (cnt_tc_c) begin
          state_d    = ST_DONE;
          wb_valid_d = 1'b1;
          wb_rd_d    = RSTATUS;
          wb_data_d  = DIV_CODE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_multdiv_stall_controller.sv
// Randomized scoreboard bench for multdiv_stall_controller.
module tb_multdiv_stall_controller;

  localparam int          TIMEOUT  = 40;
  localparam logic [4:0]  RSTATUS  = 5'd30;
  localparam logic [31:0] MULC     = 32'd4;
  localparam logic [31:0] DIVC     = 32'd5;

  logic        clock, reset;
  logic        i_start_mul, i_start_div, i_flush;
  logic [4:0]  i_rd;
  logic        data_resultRDY, data_exception;
  logic [31:0] data_result;
  logic        ctrl_MULT, ctrl_DIV, o_stall, o_wb_valid, o_busy;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_en  = 0;

  multdiv_stall_controller dut (
    .clock          (clock),
    .reset          (reset),
    .i_start_mul    (i_start_mul),
    .i_start_div    (i_start_div),
    .i_rd           (i_rd),
    .i_flush        (i_flush),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .data_result    (data_result),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .o_stall        (o_stall),
    .o_wb_valid     (o_wb_valid),
    .o_wb_rd        (o_wb_rd),
    .o_wb_data      (o_wb_data),
    .o_busy         (o_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every writeback strobe must match the oldest expected entry
  always @(negedge clock) begin
    wb_t e;
    if (mon_en && o_wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%h, required no writeback", o_wb_rd, o_wb_data);
      end else begin
        e = exp_q.pop_front();
        check("wb_rd", 32'(o_wb_rd), 32'(e.rd));
        check("wb_data", o_wb_data, e.data);
      end
    end
  end

  task automatic clear_inputs();
    i_start_mul = 0; i_start_div = 0; i_flush = 0; i_rd = '0;
    data_resultRDY = 0; data_exception = 0; data_result = '0;
  endtask

  // Idle cycles with stray ready pulses that must be ignored
  task automatic idle_gap(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      clear_inputs();
      data_resultRDY = 1'($urandom);
      data_result    = $urandom;
    end
    @(posedge clock); #1;
    clear_inputs();
  endtask

  // One transaction; lat = cycles from start pulse to ready, flush_at = BUSY index or -1
  task automatic run_txn(input bit m, input bit d, input logic [4:0] rd, input int lat,
                         input bit exc, input int flush_at, input logic [31:0] data, input bit poke);
    bit  eff_mul = m;
    int  ready_idx = lat - 1;
    int  end_idx;
    bit  flushed = 0;
    bit  wb_exp = 0;
    wb_t e;
    int  stall_cnt = 0;
    int  early = 0;
    int  pulses = 0;

    end_idx = (ready_idx < TIMEOUT - 1) ? ready_idx : TIMEOUT - 1;
    if (flush_at >= 0 && flush_at <= end_idx) begin
      flushed = 1;
      end_idx = flush_at;
    end
    if (!flushed) begin
      if (ready_idx <= TIMEOUT - 1) begin
        if (exc) begin
          e.rd = RSTATUS; e.data = eff_mul ? MULC : DIVC; wb_exp = 1;
        end else if (rd != 5'd0) begin
          e.rd = rd; e.data = data; wb_exp = 1;
        end
      end else begin
        e.rd = RSTATUS; e.data = DIVC; wb_exp = 1;
      end
      if (wb_exp) exp_q.push_back(e);
    end

    // Request cycle
    i_start_mul = m; i_start_div = d; i_rd = rd; i_flush = 0; data_resultRDY = 0;
    @(negedge clock);
    check("idle_busy", 32'(o_busy), 32'd0);
    if (o_stall) stall_cnt++;

    // Start-pulse cycle
    @(posedge clock); #1;
    i_start_mul = 0; i_start_div = 0; i_rd = 5'($urandom);
    data_resultRDY = 1'($urandom); data_result = $urandom;
    @(negedge clock);
    if (o_stall) stall_cnt++;
    check("ctrl_mult_start", 32'(ctrl_MULT), 32'(eff_mul));
    check("ctrl_div_start", 32'(ctrl_DIV), 32'(!eff_mul));
    if (o_wb_valid) early++;

    // BUSY cycles up to ready, timeout or flush
    for (int i = 0; i <= end_idx; i++) begin
      @(posedge clock); #1;
      data_resultRDY = (i == ready_idx);
      data_exception = (i == ready_idx) ? exc : 1'($urandom);
      data_result    = (i == ready_idx) ? data : $urandom;
      i_flush        = flushed && (i == flush_at);
      @(negedge clock);
      if (o_stall) stall_cnt++;
      if (ctrl_MULT || ctrl_DIV) pulses++;
      if (o_wb_valid) early++;
    end
    check("stall_cycles", 32'(stall_cnt), 32'(end_idx + 3));
    check("extra_start_pulse", 32'(pulses), 32'd0);
    check("wb_early", 32'(early), 32'd0);

    // DONE cycle (or IDLE after a flush)
    @(posedge clock); #1;
    data_resultRDY = 1'($urandom); data_result = $urandom;
    i_flush = flushed ? 1'b0 : 1'($urandom);
    i_start_mul = poke && !flushed;
    i_rd = 5'($urandom);
    @(negedge clock);
    check("stall_after", 32'(o_stall), 32'd0);
    check("busy_after", 32'(o_busy), 32'(!flushed));
    check("wb_valid_done", 32'(o_wb_valid), 32'(wb_exp));

    @(posedge clock); #1;
    clear_inputs();
  endtask

  initial begin
    int sel, lat, fl;
    bit m, d;
    logic [4:0] rd;

    clear_inputs();
    reset = 0;
    #12;
    @(negedge clock);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_wb_valid", 32'(o_wb_valid), 32'd0);
    check("rst_wb_rd", 32'(o_wb_rd), 32'd0);
    check("rst_wb_data", o_wb_data, 32'd0);
    check("rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    @(posedge clock); #1;
    reset = 1;
    mon_en = 1;
    idle_gap(2);

    // Directed cases
    run_txn(1, 0, 5'd7, 17, 0, -1, 32'hFFFF_FFF4, 0);
    idle_gap(1);
    run_txn(0, 1, 5'd8, 6, 1, -1, 32'h1234_5678, 0);
    run_txn(1, 1, 5'd9, 3, 0, -1, 32'hCAFE_0009, 1);
    run_txn(1, 0, 5'd10, 10, 0, 3, 32'hDEAD_BEEF, 0);
    idle_gap(15);
    run_txn(0, 1, 5'd11, 1000, 0, -1, 32'h0, 1);
    run_txn(1, 0, 5'd12, 4, 0, -1, 32'h0000_0C0C, 0);
    run_txn(1, 0, 5'd13, TIMEOUT, 0, -1, 32'h0000_ABCD, 0);
    run_txn(0, 1, 5'd0, 2, 0, -1, 32'h5555_5555, 0);
    run_txn(1, 0, 5'd0, 5, 1, -1, 32'h0, 0);
    run_txn(0, 1, 5'd14, 1, 0, -1, 32'h7777_0001, 0);

    // Flush in IDLE blocks acceptance
    i_start_mul = 1; i_flush = 1; i_rd = 5'd15;
    @(negedge clock);
    check("stall_flush_idle", 32'(o_stall), 32'd0);
    @(posedge clock); #1;
    clear_inputs();
    @(negedge clock);
    check("flush_blocks", 32'(o_busy), 32'd0);
    idle_gap(1);

    // Randomized transactions
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 2);
      m = (sel != 1);
      d = (sel != 0);
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      case ($urandom_range(0, 9))
        0:       lat = TIMEOUT;
        1:       lat = TIMEOUT + 1 + $urandom_range(0, 10);
        default: lat = $urandom_range(1, 30);
      endcase
      fl = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 12) : -1;
      run_txn(m, d, rd, lat, ($urandom_range(0, 3) == 0), fl, $urandom, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of BUSY
    i_start_div = 1; i_rd = 5'd5;
    @(posedge clock); #1;
    clear_inputs();
    repeat (5) @(posedge clock);
    #3;
    reset = 0;
    #1;
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_stall", 32'(o_stall), 32'd0);
    check("arst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    check("arst_wb_valid", 32'(o_wb_valid), 32'd0);
    check("arst_wb_rd", 32'(o_wb_rd), 32'd0);
    check("arst_wb_data", o_wb_data, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1;
    idle_gap(50);
    @(negedge clock);
    check("arst_idle_after", 32'(o_busy), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
